// File: rtl/l2_pkg.sv
// L2 cache controller shared types and constants.
// Way geometry, sweep bound and controller state encoding.
package l2_pkg;

    localparam int INDEX_W    = 10;
    localparam int ADDR_W     = 26;
    localparam int TAG_W      = ADDR_W - INDEX_W;
    localparam int FLUSH_LAST = (1 << INDEX_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_MISS_RD,
        S_WR_MEM,
        S_FLUSH
    } l2_state_e;

endpackage

// File: rtl/l2_cache_ctrl_sweeper.sv
// Invalidate sweep bookkeeping: index counter, busy flag, pending latch.
// done_o pulses while the last index is being issued.
module l2_flush_sweeper #(
    parameter int INDEX_W        = 10,
    parameter bit FLUSH_ON_RESET = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               flush_req_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               pending_o,
    output logic               done_o,
    output logic [INDEX_W-1:0] idx_o
);

    localparam logic [INDEX_W-1:0] LAST = '1;

    logic               busy_q, busy_d;
    logic               pend_q, pend_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;

    assign done_o    = busy_q && (cnt_q == LAST);
    assign busy_o    = busy_q;
    assign pending_o = pend_q;
    assign idx_o     = cnt_q;

    // Count through every index while busy; requests seen mid-sweep are dropped
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (busy_q) begin
            cnt_d = cnt_q + INDEX_W'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            busy_d = 1'b1;
        end
        if (start_i) begin
            pend_d = 1'b0;
        end else if (flush_req_i && !busy_q) begin
            pend_d = 1'b1;
        end
    end

    // Sweep state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= FLUSH_ON_RESET;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/l2_cache_ctrl.sv
// Direct-mapped L2 way sequencer: lookup, read-miss fill, write-through,
// invalidate sweep and arbitration of the single way write port.
module l2_cache_ctrl #(
    parameter int INDEX_W        = l2_pkg::INDEX_W,
    parameter int ADDR_W         = l2_pkg::ADDR_W,
    parameter bit FLUSH_ON_RESET = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic [ADDR_W-1:0] way_rda,
    input  logic [31:0]       way_rdd,
    input  logic              way_rdmatch,
    output logic [ADDR_W-1:0] way_wra,
    output logic [31:0]       way_wrd,
    output logic [3:0]        way_wrm,
    output logic              way_wr,
    output logic              way_clr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    import l2_pkg::l2_state_e, l2_pkg::S_IDLE, l2_pkg::S_LOOKUP;
    import l2_pkg::S_CHECK, l2_pkg::S_MISS_RD, l2_pkg::S_WR_MEM;
    import l2_pkg::S_FLUSH;

    localparam int PAD_W = ADDR_W - INDEX_W;

    l2_state_e state_q, state_d;

    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               hit_q, hit_d;

    logic               accept, start;
    logic               sw_busy, sw_pend, sw_done;
    logic [INDEX_W-1:0] sw_idx;
    logic [ADDR_W-1:0]  sweep_addr;

    logic               cpu_ack_q, cpu_ack_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic               way_wr_q, way_wr_d;
    logic               way_clr_q, way_clr_d;
    logic [ADDR_W-1:0]  way_wra_q, way_wra_d;
    logic [31:0]        way_wrd_q, way_wrd_d;
    logic [3:0]         way_wrm_q, way_wrm_d;

    // A pending flush wins over a new request; the ack cycle blocks re-acceptance
    assign start      = (state_q == S_IDLE) && sw_pend;
    assign accept     = (state_q == S_IDLE) && !sw_pend && cpu_req && !cpu_ack_q;
    assign sweep_addr = {{PAD_W{1'b0}}, sw_idx};

    l2_flush_sweeper #(
        .INDEX_W        (INDEX_W),
        .FLUSH_ON_RESET (FLUSH_ON_RESET)
    ) u_sweeper (
        .CLK         (CLK),
        .RST         (RST),
        .flush_req_i (flush_req),
        .start_i     (start),
        .busy_o      (sw_busy),
        .pending_o   (sw_pend),
        .done_o      (sw_done),
        .idx_o       (sw_idx)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FLUSH_ON_RESET ? S_FLUSH : S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (sw_pend) begin
                    state_d = S_FLUSH;
                end else if (accept) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (we_q) begin
                    state_d = S_WR_MEM;
                end else if (!way_rdmatch) begin
                    state_d = S_MISS_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MISS_RD: if (mem_ack) state_d = S_IDLE;
            S_WR_MEM:  if (mem_ack) state_d = S_IDLE;
            S_FLUSH:   if (sw_done) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Capture the CPU request when it is accepted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            hit_q   <= 1'b0;
        end else begin
            hit_q <= hit_d;
            if (accept) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
                be_q    <= cpu_be;
            end
        end
    end

    // Output logic: next values for every registered strobe and bus
    always_comb begin
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        way_wr_d    = 1'b0;
        way_clr_d   = 1'b0;
        way_wra_d   = accept ? cpu_addr : addr_q;
        way_wrd_d   = way_wrd_q;
        way_wrm_d   = way_wrm_q;
        hit_d       = hit_q;
        unique case (state_q)
            S_CHECK: begin
                if (we_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    mem_be_d    = be_q;
                    hit_d       = way_rdmatch;
                end else if (way_rdmatch) begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = way_rdd;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                    mem_be_d   = 4'hF;
                end
            end
            S_MISS_RD: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = mem_rdata;
                    way_wr_d    = 1'b1;
                    way_wrm_d   = 4'hF;
                    way_wrd_d   = mem_rdata;
                end
            end
            S_WR_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    cpu_ack_d = 1'b1;
                    if (hit_q) begin
                        way_wr_d  = 1'b1;
                        way_wrm_d = be_q;
                        way_wrd_d = wdata_q;
                    end
                end
            end
            S_FLUSH: begin
                way_wr_d  = 1'b1;
                way_clr_d = 1'b1;
                way_wrm_d = 4'hF;
                way_wra_d = sweep_addr;
            end
            default: begin
            end
        endcase
    end

    // Output registers; reset drops every strobe immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            way_wr_q    <= 1'b0;
            way_clr_q   <= 1'b0;
            way_wra_q   <= '0;
            way_wrd_q   <= '0;
            way_wrm_q   <= '0;
        end else begin
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            way_wr_q    <= way_wr_d;
            way_clr_q   <= way_clr_d;
            way_wra_q   <= way_wra_d;
            way_wrd_q   <= way_wrd_d;
            way_wrm_q   <= way_wrm_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign flush_busy = sw_busy;
    assign way_rda    = addr_q;
    assign way_wra    = way_wra_q;
    assign way_wrd    = way_wrd_q;
    assign way_wrm    = way_wrm_q;
    assign way_wr     = way_wr_q;
    assign way_clr    = way_clr_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Scoreboard bench for l2_cache_ctrl: directed transactions push
// expected acks, way writes and memory requests; monitors pop and compare.
module tb_l2_cache_ctrl;

    import l2_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [3:0]        m;
        logic              clr;
    } wr_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [3:0]        be;
    } mem_t;

    typedef struct {
        logic        chk;
        logic [31:0] d;
    } ack_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_be;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic              flush_req, flush_busy;
    logic [ADDR_W-1:0] way_rda, way_wra;
    logic [31:0]       way_rdd, way_wrd;
    logic              way_rdmatch;
    logic [3:0]        way_wrm;
    logic              way_wr, way_clr;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    wr_t  exp_wr[$];
    mem_t exp_mem[$];
    ack_t exp_ack[$];
    wr_t  ew;
    mem_t em;
    ack_t ea;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int mem_cnt = 0;
    logic mem_prev = 1'b0;
    int mem_lat = 5;
    logic [31:0] mem_data = '0;

    always #5 CLK = ~CLK;

    l2_cache_ctrl dut (
        .CLK (CLK), .RST (RST),
        .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr),
        .cpu_wdata (cpu_wdata), .cpu_be (cpu_be),
        .cpu_ack (cpu_ack), .cpu_rdata (cpu_rdata),
        .flush_req (flush_req), .flush_busy (flush_busy),
        .way_rda (way_rda), .way_rdd (way_rdd), .way_rdmatch (way_rdmatch),
        .way_wra (way_wra), .way_wrd (way_wrd), .way_wrm (way_wrm),
        .way_wr (way_wr), .way_clr (way_clr),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_be (mem_be),
        .mem_ack (mem_ack), .mem_rdata (mem_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_flush();
        for (int i = 0; i <= FLUSH_LAST; i++) begin
            exp_wr.push_back('{a: ADDR_W'(i), d: 32'h0, m: 4'hF, clr: 1'b1});
        end
    endtask

    task automatic issue(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_be    = be;
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!cpu_ack && lat < 2000);
        if (!cpu_ack) fail("ack_timeout", 64'(lat), 0);
        cpu_req = 1'b0;
    endtask

    task automatic sweep_len(output int n, input bit poke);
        n = 0;
        while (flush_busy && n < 3000) begin
            if (poke) flush_req = (n == 500);
            n++;
            @(negedge CLK);
        end
        flush_req = 1'b0;
    endtask

    // Memory model: acknowledge each request mem_lat cycles after it appears
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge CLK);
            if (mem_req && !RST) begin
                repeat (mem_lat - 1) @(negedge CLK);
                if (mem_req && !RST) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_data;
                    @(negedge CLK);
                    mem_ack   = 1'b0;
                    mem_rdata = '0;
                end
            end
        end
    end

    // Monitor: pop and compare whenever the DUT presents an output event
    always @(negedge CLK) begin
        if (!RST) begin
            if (cpu_ack) begin
                if (exp_ack.size() == 0) begin
                    fail("ack_unexpected", 64'(cpu_rdata), 0);
                end else begin
                    ea = exp_ack.pop_front();
                    if (ea.chk) chk("cpu_rdata", 64'(cpu_rdata), 64'(ea.d));
                end
            end
            if (way_wr) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    fail("way_wr_unexpected", 64'(way_wra), 0);
                end else begin
                    ew = exp_wr.pop_front();
                    chk("way_wra", 64'(way_wra), 64'(ew.a));
                    chk("way_wrm", 64'(way_wrm), 64'(ew.m));
                    chk("way_clr", 64'(way_clr), 64'(ew.clr));
                    if (!ew.clr) chk("way_wrd", 64'(way_wrd), 64'(ew.d));
                end
            end
            if (mem_req && !mem_prev) begin
                mem_cnt++;
                if (exp_mem.size() == 0) begin
                    fail("mem_req_unexpected", 64'(mem_addr), 0);
                end else begin
                    em = exp_mem.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(em.we));
                    chk("mem_addr", 64'(mem_addr), 64'(em.a));
                    chk("mem_be", 64'(mem_be), 64'(em.be));
                    if (em.we) chk("mem_wdata", 64'(mem_wdata), 64'(em.d));
                end
            end
        end
        mem_prev <= mem_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, k, wr0, mem0;
        RST = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        flush_req = 0; way_rdd = '0; way_rdmatch = 0;
        #12;
        chk("rst_strobes", 64'({cpu_ack, mem_req, way_wr, way_clr}), 0);
        chk("rst_flush_busy", 64'(flush_busy), 1);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_way_addr", 64'({way_wra, way_rda}), 0);
        push_flush();
        @(negedge CLK);
        RST = 1'b0;
        sweep_len(n, 1'b0);
        chk("reset_sweep_len", 64'(n), 64'(FLUSH_LAST + 1));
        @(negedge CLK);
        @(negedge CLK);

        // Read miss with fill
        mem_lat = 5; mem_data = 32'hDEADBEEF; way_rdmatch = 0;
        exp_mem.push_back('{we: 0, a: 26'h40, d: 0, be: 4'hF});
        exp_wr.push_back('{a: 26'h40, d: 32'hDEADBEEF, m: 4'hF, clr: 0});
        exp_ack.push_back('{chk: 1, d: 32'hDEADBEEF});
        wr0 = wr_cnt;
        issue(0, 26'h40, 0, 0);
        wait_ack(lat);
        repeat (2) @(negedge CLK);
        chk("miss_fill_count", 64'(wr_cnt - wr0), 1);

        // Read hit: three-cycle latency, no memory traffic
        way_rdmatch = 1; way_rdd = 32'hDEADBEEF;
        exp_ack.push_back('{chk: 1, d: 32'hDEADBEEF});
        wr0 = wr_cnt; mem0 = mem_cnt;
        issue(0, 26'h40, 0, 0);
        wait_ack(lat);
        chk("hit_latency", 64'(lat), 3);
        repeat (2) @(negedge CLK);
        chk("hit_no_mem", 64'(mem_cnt - mem0), 0);
        chk("hit_no_wr", 64'(wr_cnt - wr0), 0);

        // Write hit: write-through plus masked way update
        way_rdmatch = 1;
        exp_mem.push_back('{we: 1, a: 26'h123, d: 32'h12345678, be: 4'b0011});
        exp_wr.push_back('{a: 26'h123, d: 32'h12345678, m: 4'b0011, clr: 0});
        exp_ack.push_back('{chk: 0, d: 0});
        wr0 = wr_cnt;
        issue(1, 26'h123, 32'h12345678, 4'b0011);
        wait_ack(lat);
        repeat (2) @(negedge CLK);
        chk("wr_hit_count", 64'(wr_cnt - wr0), 1);

        // Write miss: memory write only, no allocation
        way_rdmatch = 0;
        exp_mem.push_back('{we: 1, a: 26'h2A5, d: 32'hCAFEF00D, be: 4'b1100});
        exp_ack.push_back('{chk: 0, d: 0});
        wr0 = wr_cnt;
        issue(1, 26'h2A5, 32'hCAFEF00D, 4'b1100);
        wait_ack(lat);
        repeat (2) @(negedge CLK);
        chk("wr_miss_no_wr", 64'(wr_cnt - wr0), 0);

        // Flush requested during a read miss: miss completes first
        way_rdmatch = 0; mem_data = 32'h0BADF00D;
        exp_mem.push_back('{we: 0, a: 26'h3FF, d: 0, be: 4'hF});
        exp_wr.push_back('{a: 26'h3FF, d: 32'h0BADF00D, m: 4'hF, clr: 0});
        exp_ack.push_back('{chk: 1, d: 32'h0BADF00D});
        push_flush();
        issue(0, 26'h3FF, 0, 0);
        k = 0;
        while (!mem_req && k < 20) begin
            @(negedge CLK);
            k++;
        end
        chk("miss_mem_req", 64'(mem_req), 1);
        flush_req = 1'b1;
        @(negedge CLK);
        flush_req = 1'b0;
        chk("busy_during_miss", 64'(flush_busy), 0);
        wait_ack(lat);
        @(negedge CLK);
        chk("sweep_after_miss", 64'(flush_busy), 1);
        sweep_len(n, 1'b1);
        chk("req_sweep_len", 64'(n), 64'(FLUSH_LAST + 1));
        repeat (20) @(negedge CLK);
        chk("no_second_sweep", 64'(flush_busy), 0);
        chk("sweep_writes_done", 64'(exp_wr.size()), 0);

        // Reset while a memory request is outstanding
        mem_lat = 40; way_rdmatch = 0;
        exp_mem.push_back('{we: 0, a: 26'h155, d: 0, be: 4'hF});
        issue(0, 26'h155, 0, 0);
        k = 0;
        while (!mem_req && k < 20) begin
            @(negedge CLK);
            k++;
        end
        chk("pre_rst_mem_req", 64'(mem_req), 1);
        #2 RST = 1'b1;
        #1;
        chk("rst_async_strobes", 64'({mem_req, cpu_ack, way_wr}), 0);
        chk("rst_async_busy", 64'(flush_busy), 1);
        cpu_req = 1'b0;
        @(negedge CLK);
        mem_lat = 5;
        push_flush();
        RST = 1'b0;
        sweep_len(n, 1'b0);
        chk("rst2_sweep_len", 64'(n), 64'(FLUSH_LAST + 1));
        repeat (2) @(negedge CLK);

        // Normal operation resumes after the restart
        way_rdmatch = 1; way_rdd = 32'h5A5AA5A5;
        exp_ack.push_back('{chk: 1, d: 32'h5A5AA5A5});
        issue(0, 26'h77, 0, 0);
        wait_ack(lat);
        chk("post_rst_latency", 64'(lat), 3);
        repeat (3) @(negedge CLK);

        chk("ack_queue_empty", 64'(exp_ack.size()), 0);
        chk("wr_queue_empty", 64'(exp_wr.size()), 0);
        chk("mem_queue_empty", 64'(exp_mem.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
